// File: rtl/perf_counter_sequencer.sv
// Round-robin Avalon-MM write sequencer for the 4-section performance-counter slave.
// Define PERF_COUNTER_SNAPSHOT_EN to include the snapshot read path (RD_LO/RD_HI/RD_EV/CAP).

module perf_counter_sequencer #(
  parameter int SECTIONS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SECTIONS-1:0] start_req,
  input  logic [SECTIONS-1:0] stop_req,
  input  logic                clear_req,
  input  logic                snap_req,
  input  logic [1:0]          snap_sel,
  output logic [3:0]          pc_address,
  output logic                pc_write,
  output logic                pc_begintransfer,
  output logic [31:0]         pc_writedata,
  input  logic [31:0]         pc_readdata,
  output logic [63:0]         snap_time,
  output logic [31:0]         snap_events,
  output logic                snap_valid,
  output logic                busy
);

  localparam logic [1:0] LAST_SEC = 2'(SECTIONS - 1);

`ifdef PERF_COUNTER_SNAPSHOT_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_LO, S_RD_HI, S_RD_EV, S_CAP} state_t;
`else
  typedef enum logic {S_IDLE, S_WR} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [SECTIONS-1:0] r_go_pend, r_stop_pend;
  logic                r_clr_pend;
  logic [1:0]          r_rr, w_rr_nxt;
  logic [3:0]          r_cmd_addr, w_cmd_addr;
  logic                r_cmd_one, w_cmd_one;
  logic                w_issue_clr;
  logic [3:0]          w_issue_go, w_issue_stop;
  logic [3:0]          w_go4, w_stop4;
  logic                w_found;
  logic [1:0]          w_pick, w_probe;
  logic                w_snap_busy;

  function automatic logic [1:0] wrap_inc(input logic [1:0] x);
    return (x == LAST_SEC) ? 2'd0 : x + 2'd1;
  endfunction

  assign w_go4   = 4'(r_go_pend);
  assign w_stop4 = 4'(r_stop_pend);

  // Round-robin search starting at r_rr over sections with anything pending.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_probe = r_rr;
    for (int i = 0; i < SECTIONS; i++) begin
      if (!w_found && (w_go4[w_probe] || w_stop4[w_probe])) begin
        w_found = 1'b1;
        w_pick  = w_probe;
      end
      w_probe = wrap_inc(w_probe);
    end
  end

`ifdef PERF_COUNTER_SNAPSHOT_EN
  logic        r_snap_pend;
  logic [1:0]  r_snap_sel;
  logic [1:0]  r_sec, w_sec_nxt;
  logic        w_issue_snap;
  logic [31:0] r_time_lo, r_time_hi, r_snap_events;
  logic [63:0] r_snap_time;
  logic        r_snap_valid;

  assign w_snap_busy = r_snap_pend;
`else
  assign w_snap_busy = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_issue_clr  = 1'b0;
    w_issue_go   = 4'd0;
    w_issue_stop = 4'd0;
    w_cmd_addr   = r_cmd_addr;
    w_cmd_one    = r_cmd_one;
    w_rr_nxt     = r_rr;
`ifdef PERF_COUNTER_SNAPSHOT_EN
    w_issue_snap = 1'b0;
    w_sec_nxt    = r_sec;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_clr_pend) begin
          w_issue_clr = 1'b1;
          w_state_nxt = S_WR;
          w_cmd_addr  = 4'd0;
          w_cmd_one   = 1'b1;
        end else if (w_found) begin
          w_state_nxt = S_WR;
          w_cmd_one   = 1'b0;
          w_rr_nxt    = wrap_inc(w_pick);
          if (w_stop4[w_pick]) begin
            w_issue_stop[w_pick] = 1'b1;
            w_cmd_addr           = {w_pick, 2'b00};
          end else begin
            w_issue_go[w_pick] = 1'b1;
            w_cmd_addr         = {w_pick, 2'b01};
          end
        end
`ifdef PERF_COUNTER_SNAPSHOT_EN
        else if (r_snap_pend) begin
          w_issue_snap = 1'b1;
          w_state_nxt  = S_RD_LO;
          w_sec_nxt    = 2'(32'(r_snap_sel) % 32'(SECTIONS));
        end
`endif
      end
      S_WR:    w_state_nxt = S_IDLE;
`ifdef PERF_COUNTER_SNAPSHOT_EN
      S_RD_LO: w_state_nxt = S_RD_HI;
      S_RD_HI: w_state_nxt = S_RD_EV;
      S_RD_EV: w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr       <= 2'd0;
      r_cmd_addr <= 4'd0;
      r_cmd_one  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state    <= w_state_nxt;
      r_rr       <= w_rr_nxt;
      r_cmd_addr <= w_cmd_addr;
      r_cmd_one  <= w_cmd_one;
    end
  end

  // A new request wins over the issue-clear of the same bit, so nothing is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_go_pend   <= '0;
      r_stop_pend <= '0;
      r_clr_pend  <= 1'b0;
    end else if (clear_req) begin
      r_go_pend   <= '0;
      r_stop_pend <= '0;
      r_clr_pend  <= 1'b1;
    end else begin
      r_clr_pend  <= r_clr_pend & ~w_issue_clr;
      r_stop_pend <= stop_req | (r_stop_pend & ~w_issue_stop[SECTIONS-1:0]);
      r_go_pend   <= ~stop_req & (start_req | (r_go_pend & ~w_issue_go[SECTIONS-1:0]));
    end
  end

`ifdef PERF_COUNTER_SNAPSHOT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_pend <= 1'b0;
      r_snap_sel  <= 2'd0;
      r_sec       <= 2'd0;
    end else begin
      r_sec <= w_sec_nxt;
      if (snap_req && !clear_req) begin
        r_snap_pend <= 1'b1;
        r_snap_sel  <= snap_sel;
      end else begin
        r_snap_pend <= r_snap_pend & ~w_issue_snap;
      end
    end
  end

  // Read data lags the address by one cycle, so each state latches the previous word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_time_lo     <= '0;
      r_time_hi     <= '0;
      r_snap_time   <= '0;
      r_snap_events <= '0;
      r_snap_valid  <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;
      case (r_state)
        S_RD_HI: r_time_lo <= pc_readdata;
        S_RD_EV: r_time_hi <= pc_readdata;
        S_CAP: begin
          r_snap_time   <= {r_time_hi, r_time_lo};
          r_snap_events <= pc_readdata;
          r_snap_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign snap_time   = r_snap_time;
  assign snap_events = r_snap_events;
  assign snap_valid  = r_snap_valid;
`else
  logic w_unused;
  assign w_unused    = ^{pc_readdata, snap_req, snap_sel};
  assign snap_time   = '0;
  assign snap_events = '0;
  assign snap_valid  = 1'b0;
`endif

  always_comb begin
    pc_write         = 1'b0;
    pc_begintransfer = 1'b0;
    pc_address       = 4'd0;
    pc_writedata     = 32'd0;
    case (r_state)
      S_WR: begin
        pc_write         = 1'b1;
        pc_begintransfer = 1'b1;
        pc_address       = r_cmd_addr;
        pc_writedata     = {31'd0, r_cmd_one};
      end
`ifdef PERF_COUNTER_SNAPSHOT_EN
      S_RD_LO: pc_address = {r_sec, 2'b00};
      S_RD_HI: pc_address = {r_sec, 2'b01};
      S_RD_EV: pc_address = {r_sec, 2'b10};
`endif
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE) | r_clr_pend | (|r_go_pend) | (|r_stop_pend) | w_snap_busy;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Self-checking bench for perf_counter_sequencer: directed steps plus random requests
// checked every cycle against a transaction-queue reference model.

module tb_perf_counter_sequencer;

  localparam int SECTIONS = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [SECTIONS-1:0] start_req = '0, stop_req = '0;
  logic                clear_req = 1'b0, snap_req = 1'b0;
  logic [1:0]          snap_sel = 2'd0;
  logic [3:0]          pc_address;
  logic                pc_write, pc_begintransfer;
  logic [31:0]         pc_writedata;
  logic [31:0]         pc_readdata;
  logic [63:0]         snap_time;
  logic [31:0]         snap_events;
  logic                snap_valid, busy;

  always #5 clk = ~clk;

  perf_counter_sequencer #(.SECTIONS(SECTIONS)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_req(start_req), .stop_req(stop_req),
    .clear_req(clear_req), .snap_req(snap_req), .snap_sel(snap_sel),
    .pc_address(pc_address), .pc_write(pc_write),
    .pc_begintransfer(pc_begintransfer), .pc_writedata(pc_writedata),
    .pc_readdata(pc_readdata),
    .snap_time(snap_time), .snap_events(snap_events),
    .snap_valid(snap_valid), .busy(busy)
  );

  // Counter slave with one-cycle registered read data.
  logic [31:0] mem [16];
  always @(posedge clk) pc_readdata <= mem[pc_address];

  // Reference model: each issued operation becomes a queue of expected bus cycles.
  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        cap;
    logic [1:0]  sec;
  } beat_t;

  beat_t       q[$];
  logic [3:0]  m_go, m_stop;
  logic        m_clr, m_snap, m_valid;
  int          m_sel, m_rr;
  logic [63:0] m_time;
  logic [31:0] m_ev;

  int         n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0, n_act = 0;
  logic [3:0] wlog[$];

  function automatic beat_t mk(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                               input logic cap, input logic [1:0] sec);
    beat_t b;
    b.wr = wr; b.addr = addr; b.data = data; b.cap = cap; b.sec = sec;
    return b;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_go = '0; m_stop = '0; m_clr = 1'b0; m_snap = 1'b0; m_valid = 1'b0;
    m_sel = 0; m_rr = 0; m_time = '0; m_ev = '0;
  endfunction

  function automatic void model_edge(input logic [3:0] st, input logic [3:0] sp, input logic clr,
                                     input logic snp, input logic [1:0] sel);
    beat_t b;
    m_valid = 1'b0;
    if (q.size() != 0) begin
      b = q.pop_front();
      if (b.cap) begin
        m_time  = {mem[4*b.sec+1], mem[4*b.sec]};
        m_ev    = mem[4*b.sec+2];
        m_valid = 1'b1;
      end
    end else if (m_clr) begin
      m_clr = 1'b0;
      q.push_back(mk(1'b1, 4'd0, 32'd1, 1'b0, 2'd0));
    end else if ((m_go | m_stop) != 4'd0) begin
      for (int k = 0; k < SECTIONS; k++) begin
        int s;
        s = (m_rr + k) % SECTIONS;
        if (m_stop[s] || m_go[s]) begin
          if (m_stop[s]) begin
            m_stop[s] = 1'b0;
            q.push_back(mk(1'b1, 4'(4*s), 32'd0, 1'b0, 2'd0));
          end else begin
            m_go[s] = 1'b0;
            q.push_back(mk(1'b1, 4'(4*s+1), 32'd0, 1'b0, 2'd0));
          end
          m_rr = (s + 1) % SECTIONS;
          break;
        end
      end
    end
`ifdef PERF_COUNTER_SNAPSHOT_EN
    else if (m_snap) begin
      int s;
      s = m_sel % SECTIONS;
      m_snap = 1'b0;
      q.push_back(mk(1'b0, 4'(4*s),   32'd0, 1'b0, 2'(s)));
      q.push_back(mk(1'b0, 4'(4*s+1), 32'd0, 1'b0, 2'(s)));
      q.push_back(mk(1'b0, 4'(4*s+2), 32'd0, 1'b0, 2'(s)));
      q.push_back(mk(1'b0, 4'd0,      32'd0, 1'b1, 2'(s)));
    end
`endif
    if (clr) begin
      m_clr = 1'b1; m_go = '0; m_stop = '0;
    end else begin
      for (int s = 0; s < SECTIONS; s++) begin
        if (sp[s]) begin
          m_stop[s] = 1'b1; m_go[s] = 1'b0;
        end else if (st[s]) begin
          m_go[s] = 1'b1;
        end
      end
`ifdef PERF_COUNTER_SNAPSHOT_EN
      if (snp) begin
        m_snap = 1'b1; m_sel = int'(sel);
      end
`endif
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic        e_wr;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    e_wr   = (q.size() != 0) ? q[0].wr   : 1'b0;
    e_addr = (q.size() != 0) ? q[0].addr : 4'd0;
    e_data = (q.size() != 0) ? q[0].data : 32'd0;
    e_busy = (q.size() != 0) || m_clr || m_snap || ((m_go | m_stop) != 4'd0);
    check("pc_address", 64'(pc_address), 64'(e_addr));
    check("pc_write", 64'(pc_write), 64'(e_wr));
    check("pc_begintransfer", 64'(pc_begintransfer), 64'(e_wr));
    check("pc_writedata", 64'(pc_writedata), 64'(e_data));
    check("busy", 64'(busy), 64'(e_busy));
    check("snap_valid", 64'(snap_valid), 64'(m_valid));
    check("snap_time", snap_time, m_time);
    check("snap_events", 64'(snap_events), 64'(m_ev));
    if (pc_write === 1'b1) wlog.push_back(pc_address);
    if (pc_write !== 1'b0 || pc_begintransfer !== 1'b0 || pc_address !== 4'd0) n_act++;
  endtask

  task automatic step(input logic [3:0] st, input logic [3:0] sp, input logic clr,
                      input logic snp, input logic [1:0] sel);
    start_req = st; stop_req = sp; clear_req = clr; snap_req = snp; snap_sel = sel;
    @(posedge clk);
    model_edge(st, sp, clr, snp, sel);
    @(negedge clk);
    cyc++;
    start_req = '0; stop_req = '0; clear_req = 1'b0; snap_req = 1'b0; snap_sel = 2'd0;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'd0, 4'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start_req = '0; stop_req = '0; clear_req = 1'b0; snap_req = 1'b0; snap_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    compare_all();
  endtask

  task automatic check_wlog(input string tag, input int n, input logic [3:0] a0,
                            input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
    logic [3:0] e[4];
    logic [3:0] got;
    e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
    check({tag, "_count"}, 64'(wlog.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < wlog.size()) ? wlog[i] : 4'hx;
      check({tag, "_addr"}, 64'(got), 64'(e[i]));
    end
    wlog.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[12] = 32'hAAAA0001;
    mem[13] = 32'h00000002;
    mem[14] = 32'h00000007;
    model_reset();

    do_reset();
    idle(2);

    wlog.delete();
    step(4'b0010, 4'd0, 1'b0, 1'b0, 2'd0);
    idle(4);
    check_wlog("go1", 1, 4'd5, 4'd0, 4'd0, 4'd0);

    do_reset();
    step(4'b1111, 4'd0, 1'b0, 1'b0, 2'd0);
    idle(9);
    check_wlog("go_all", 4, 4'd1, 4'd5, 4'd9, 4'd13);
    step(4'b0101, 4'd0, 1'b0, 1'b0, 2'd0);
    idle(5);
    check_wlog("go02", 2, 4'd1, 4'd9, 4'd0, 4'd0);

    step(4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0);
    idle(4);
    check_wlog("start_stop2", 1, 4'd8, 4'd0, 4'd0, 4'd0);
    step(4'd0, 4'b1000, 1'b1, 1'b0, 2'd0);
    idle(4);
    check_wlog("clear", 1, 4'd0, 4'd0, 4'd0, 4'd0);

    n_act = 0;
    step(4'd0, 4'd0, 1'b0, 1'b1, 2'd3);
    idle(7);
`ifdef PERF_COUNTER_SNAPSHOT_EN
    check("snap3_time", snap_time, 64'h00000002_AAAA0001);
    check("snap3_events", 64'(snap_events), 64'd7);
    check("snap3_no_write", 64'(wlog.size()), 64'd0);

    step(4'd0, 4'd0, 1'b0, 1'b1, 2'd2);
    idle(2);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    compare_all();
    idle(6);
    check("rst_mid_time", snap_time, 64'd0);
`else
    check("nosnap_bus", 64'(n_act), 64'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [3:0] st, sp;
      for (int s = 0; s < SECTIONS; s++) begin
        st[s] = ($urandom_range(0, 7) == 0);
        sp[s] = ($urandom_range(0, 11) == 0);
      end
      step(st, sp, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
